// File: rtl/dvp_config_regfile.sv
// dvp_config_regfile
//   AXI4-lite-style config/status register file for the DVP RX subsystem.
//   REG_NUM registers, each RW, RO (live hardware status) or W1C (sticky
//   hardware event flags). AW and W are captured in independent one-deep
//   slots and committed together once the B stage can take a response.
//   Reads are single-beat with a registered R stage.
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   m_aw*/m_w*/m_b*             write address, write data, write response
//   m_ar*/m_r*                  read address, read data
//   sts_i                       RO: live value; W1C: per-bit set pulses
//   conf_o                      register contents, slice i = register i
//   wr_pulse_o                  one-cycle pulse per register updated by a bus write
//   irq_o                       OR of all W1C register bits
module dvp_config_regfile #(
  parameter int                        DATA_W       = 32,
  parameter int                        ADDR_W       = 32,
  parameter int                        MST_ID_W     = 5,
  parameter int                        TRANS_RESP_W = 2,
  parameter int                        REG_NUM      = 8,
  parameter logic [ADDR_W-1:0]         BASE_ADDR    = ADDR_W'(32'h4000_0000),
  parameter logic [REG_NUM-1:0]        RO_MASK      = REG_NUM'(1),
  parameter logic [REG_NUM-1:0]        W1C_MASK     = REG_NUM'(2),
  parameter logic [REG_NUM*DATA_W-1:0] RST_VAL      = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [MST_ID_W-1:0]         m_awid_i,
  input  logic [ADDR_W-1:0]           m_awaddr_i,
  input  logic                        m_awvalid_i,
  output logic                        m_awready_o,
  input  logic [DATA_W-1:0]           m_wdata_i,
  input  logic [DATA_W/8-1:0]         m_wstrb_i,
  input  logic                        m_wvalid_i,
  output logic                        m_wready_o,
  output logic [MST_ID_W-1:0]         m_bid_o,
  output logic [TRANS_RESP_W-1:0]     m_bresp_o,
  output logic                        m_bvalid_o,
  input  logic                        m_bready_i,
  input  logic [MST_ID_W-1:0]         m_arid_i,
  input  logic [ADDR_W-1:0]           m_araddr_i,
  input  logic                        m_arvalid_i,
  output logic                        m_arready_o,
  output logic [MST_ID_W-1:0]         m_rid_o,
  output logic [DATA_W-1:0]           m_rdata_o,
  output logic [TRANS_RESP_W-1:0]     m_rresp_o,
  output logic                        m_rvalid_o,
  input  logic                        m_rready_i,
  input  logic [REG_NUM*DATA_W-1:0]   sts_i,
  output logic [REG_NUM*DATA_W-1:0]   conf_o,
  output logic [REG_NUM-1:0]          wr_pulse_o,
  output logic                        irq_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [ADDR_W-1:0] SPAN       = ADDR_W'(REG_NUM * BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);
  localparam logic [TRANS_RESP_W-1:0] RESP_OKAY   = TRANS_RESP_W'(2'b00);
  localparam logic [TRANS_RESP_W-1:0] RESP_SLVERR = TRANS_RESP_W'(2'b10);
  localparam logic [TRANS_RESP_W-1:0] RESP_DECERR = TRANS_RESP_W'(2'b11);

  // Addresses below BASE_ADDR wrap to a huge offset and therefore miss.
  function automatic logic addr_hit(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    return (off < SPAN) && ((off & ALIGN_MASK) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] word;
    word = (addr - BASE_ADDR) / ADDR_W'(BYTES);
    return word[IDX_W-1:0];
  endfunction

  logic                    aw_full_q, w_full_q;
  logic [ADDR_W-1:0]       aw_addr_q;
  logic [MST_ID_W-1:0]     aw_id_q;
  logic [DATA_W-1:0]       w_data_q;
  logic [BYTES-1:0]        w_strb_q;
  logic                    b_valid_q, r_valid_q;
  logic [MST_ID_W-1:0]     b_id_q, r_id_q;
  logic [TRANS_RESP_W-1:0] b_resp_q, b_resp_d, r_resp_q, r_resp_d;
  logic [DATA_W-1:0]       r_data_q, r_data_d;
  logic [REG_NUM-1:0]      wr_pulse_q, wr_pulse_d;
  logic [DATA_W-1:0]       regs_q [REG_NUM];
  logic [DATA_W-1:0]       regs_d [REG_NUM];
  logic [DATA_W-1:0]       strb_mask;
  logic                    aw_hs, w_hs, ar_hs, commit;
  logic                    wr_hit, rd_hit;
  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic                    irq_d;

  assign m_awready_o = ~aw_full_q;
  assign m_wready_o  = ~w_full_q;
  assign m_arready_o = ~r_valid_q | m_rready_i;

  assign aw_hs  = m_awvalid_i & ~aw_full_q;
  assign w_hs   = m_wvalid_i & ~w_full_q;
  assign ar_hs  = m_arvalid_i & m_arready_o;
  assign commit = aw_full_q & w_full_q & (~b_valid_q | m_bready_i);

  assign wr_hit = addr_hit(aw_addr_q);
  assign wr_idx = addr_idx(aw_addr_q);
  assign rd_hit = addr_hit(m_araddr_i);
  assign rd_idx = addr_idx(m_araddr_i);

  always_comb begin
    strb_mask = '0;
    for (int b = 0; b < BYTES; b++) strb_mask[b*8 +: 8] = {8{w_strb_q[b]}};
  end

  always_comb begin
    wr_pulse_d = '0;
    b_resp_d   = RESP_OKAY;
    if (!wr_hit) b_resp_d = RESP_DECERR;
    for (int i = 0; i < REG_NUM; i++) begin
      if (wr_hit && wr_idx == IDX_W'(i)) begin
        if (RO_MASK[i]) b_resp_d = RESP_SLVERR;
        else            wr_pulse_d[i] = commit;
      end
    end
  end

  // Hardware set is OR-ed in after the bus clear so a coincident set wins.
  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      regs_d[i] = regs_q[i];
      if (!RO_MASK[i]) begin
        if (W1C_MASK[i]) begin
          if (wr_pulse_d[i]) regs_d[i] = regs_q[i] & ~(w_data_q & strb_mask);
          regs_d[i] = regs_d[i] | sts_i[i*DATA_W +: DATA_W];
        end else if (wr_pulse_d[i]) begin
          regs_d[i] = (regs_q[i] & ~strb_mask) | (w_data_q & strb_mask);
        end
      end
    end
  end

  // Read samples the pre-commit register value (read-before-write).
  always_comb begin
    r_data_d = '0;
    r_resp_d = RESP_DECERR;
    for (int i = 0; i < REG_NUM; i++) begin
      if (rd_hit && rd_idx == IDX_W'(i)) begin
        r_resp_d = RESP_OKAY;
        r_data_d = RO_MASK[i] ? sts_i[i*DATA_W +: DATA_W] : regs_q[i];
      end
    end
  end

  always_comb begin
    irq_d = 1'b0;
    for (int i = 0; i < REG_NUM; i++)
      if (W1C_MASK[i] && !RO_MASK[i]) irq_d = irq_d | (|regs_q[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q  <= 1'b0;
      aw_addr_q  <= '0;
      aw_id_q    <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      b_resp_q   <= '0;
      r_valid_q  <= 1'b0;
      r_id_q     <= '0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= RST_VAL[i*DATA_W +: DATA_W];
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= m_awaddr_i;
        aw_id_q   <= m_awid_i;
      end else if (commit) begin
        aw_full_q <= 1'b0;
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= m_wdata_i;
        w_strb_q <= m_wstrb_i;
      end else if (commit) begin
        w_full_q <= 1'b0;
      end
      if (commit) begin
        b_valid_q <= 1'b1;
        b_id_q    <= aw_id_q;
        b_resp_q  <= b_resp_d;
      end else if (m_bready_i) begin
        b_valid_q <= 1'b0;
      end
      if (ar_hs) begin
        r_valid_q <= 1'b1;
        r_id_q    <= m_arid_i;
        r_data_q  <= r_data_d;
        r_resp_q  <= r_resp_d;
      end else if (m_rready_i) begin
        r_valid_q <= 1'b0;
      end
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign m_bvalid_o = b_valid_q;
  assign m_bid_o    = b_id_q;
  assign m_bresp_o  = b_resp_q;
  assign m_rvalid_o = r_valid_q;
  assign m_rid_o    = r_id_q;
  assign m_rdata_o  = r_data_q;
  assign m_rresp_o  = r_resp_q;
  assign wr_pulse_o = wr_pulse_q;
  assign irq_o      = irq_d;

  for (genvar g = 0; g < REG_NUM; g++) begin : g_conf
    assign conf_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: tb/tb_dvp_config_regfile.sv
module tb_dvp_config_regfile;

  localparam logic [255:0] RST = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                  32'h1234_5678, 32'h0, 32'h0};

  typedef struct {
    logic [4:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   awid, arid, bid, rid;
  logic [31:0]  awaddr, araddr, wdata, rdata;
  logic [3:0]   wstrb;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [1:0]   bresp, rresp;
  logic [255:0] sts, conf;
  logic [7:0]   wr_pulse;
  logic         irq;

  int total = 0;
  int bad   = 0;
  exp_t bq[$];
  exp_t rq[$];

  dvp_config_regfile #(.RST_VAL(RST)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_awid_i(awid), .m_awaddr_i(awaddr), .m_awvalid_i(awvalid), .m_awready_o(awready),
    .m_wdata_i(wdata), .m_wstrb_i(wstrb), .m_wvalid_i(wvalid), .m_wready_o(wready),
    .m_bid_o(bid), .m_bresp_o(bresp), .m_bvalid_o(bvalid), .m_bready_i(bready),
    .m_arid_i(arid), .m_araddr_i(araddr), .m_arvalid_i(arvalid), .m_arready_o(arready),
    .m_rid_o(rid), .m_rdata_o(rdata), .m_rresp_o(rresp), .m_rvalid_o(rvalid),
    .m_rready_i(rready),
    .sts_i(sts), .conf_o(conf), .wr_pulse_o(wr_pulse), .irq_o(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cslice(input int i);
    return conf[i*32 +: 32];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  // Monitors: pop expectations on each B/R handshake.
  always @(negedge clk) begin
    if (rst_n && bvalid && bready) begin
      if (bq.size() == 0) timeout("b_unexpected");
      else begin
        exp_t e;
        e = bq.pop_front();
        chk("b_id", 32'(bid), 32'(e.id));
        chk("b_resp", 32'(bresp), 32'(e.resp));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rvalid && rready) begin
      if (rq.size() == 0) timeout("r_unexpected");
      else begin
        exp_t e;
        e = rq.pop_front();
        chk("r_id", 32'(rid), 32'(e.id));
        chk("r_data", rdata, e.data);
        chk("r_resp", 32'(rresp), 32'(e.resp));
      end
    end
  end

  task automatic aw_send(input logic [4:0] id, input logic [31:0] addr);
    int n;
    bit done;
    n = 0; done = 0;
    awid = id; awaddr = addr; awvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = awready;
      @(posedge clk); #1;
      n++;
      if (!done && n > 50) begin timeout("aw_handshake"); done = 1; end
    end
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb);
    int n;
    bit done;
    n = 0; done = 0;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = wready;
      @(posedge clk); #1;
      n++;
      if (!done && n > 50) begin timeout("w_handshake"); done = 1; end
    end
    wvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [4:0] id, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] resp);
    int n;
    bit done;
    n = 0; done = 0;
    rq.push_back('{id, data, resp});
    arid = id; araddr = addr; arvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = arready;
      @(posedge clk); #1;
      n++;
      if (!done && n > 50) begin timeout("ar_handshake"); done = 1; end
    end
    arvalid = 1'b0;
  endtask

  task automatic write_tx(input logic [4:0] id, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] resp);
    bq.push_back('{id, 32'h0, resp});
    fork
      aw_send(id, addr);
      w_send(data, strb);
    join
  endtask

  task automatic count_pulse(input int idx, input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (wr_pulse[idx]) cnt++;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) timeout(name);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    awid = '0; awaddr = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    arid = '0; araddr = '0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    sts = '0;
    sts[31:0] = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_conf2", cslice(2), 32'h1234_5678);
    chk("rst_conf1", cslice(1), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_bvalid", 32'(bvalid), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_ready", {29'h0, awready, wready, arready}, 32'h7);
    chk("rst_pulse", 32'(wr_pulse), 32'h0);
    @(posedge clk); #1;

    // 1) Read reset value, latency one cycle
    ar_send(5'd3, 32'h4000_0008, 32'h1234_5678, 2'b00);
    chk("r_latency", 32'(rvalid), 32'h1);
    drain("drain_t1");

    // 2) W ahead of AW by three cycles, partial strobes
    bq.push_back('{5'd7, 32'h0, 2'b00});
    fork
      w_send(32'hAABB_CCDD, 4'b0101);
      begin
        repeat (3) begin @(posedge clk); #1; end
        aw_send(5'd7, 32'h4000_0008);
      end
    join
    count_pulse(2, 5, cnt);
    chk("t2_pulse_cnt", 32'(cnt), 32'h1);
    chk("t2_conf2", cslice(2), 32'h12BB_56DD);
    @(posedge clk); #1;
    ar_send(5'd1, 32'h4000_0008, 32'h12BB_56DD, 2'b00);
    drain("drain_t2");

    // wstrb = 0: no change, pulse still fires
    write_tx(5'd8, 32'h4000_0008, 32'hFFFF_FFFF, 4'b0000, 2'b00);
    count_pulse(2, 4, cnt);
    chk("strb0_pulse_cnt", 32'(cnt), 32'h1);
    chk("strb0_conf2", cslice(2), 32'h12BB_56DD);

    // 3) RO write, decode misses
    @(posedge clk); #1;
    write_tx(5'd2, 32'h4000_0000, 32'hFFFF_FFFF, 4'hF, 2'b10);
    count_pulse(0, 4, cnt);
    chk("ro_pulse_cnt", 32'(cnt), 32'h0);
    chk("ro_conf0", cslice(0), 32'h0);
    @(posedge clk); #1;
    write_tx(5'd9, 32'h4000_0100, 32'hFFFF_FFFF, 4'hF, 2'b11);
    ar_send(5'd4, 32'h4000_0020, 32'h0, 2'b11);
    ar_send(5'd5, 32'h4000_0002, 32'h0, 2'b11);
    ar_send(5'd6, 32'h4000_0000, 32'hCAFE_F00D, 2'b00);
    drain("drain_t3");

    // 4) W1C set / clear / set-wins
    sts[35] = 1'b1;
    @(posedge clk); #1;
    sts[35] = 1'b0;
    @(negedge clk);
    chk("w1c_set_conf1", cslice(1), 32'h8);
    chk("w1c_set_irq", 32'(irq), 32'h1);
    @(posedge clk); #1;
    ar_send(5'd12, 32'h4000_0004, 32'h8, 2'b00);
    write_tx(5'd13, 32'h4000_0004, 32'h8, 4'hF, 2'b00);
    sts[35] = 1'b1;
    @(posedge clk); #1;
    sts[35] = 1'b0;
    @(negedge clk);
    chk("w1c_set_wins", cslice(1), 32'h8);
    chk("w1c_set_wins_irq", 32'(irq), 32'h1);
    @(posedge clk); #1;
    write_tx(5'd14, 32'h4000_0004, 32'h8, 4'hF, 2'b00);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("w1c_clear_conf1", cslice(1), 32'h0);
    chk("w1c_clear_irq", 32'(irq), 32'h0);
    @(posedge clk); #1;
    drain("drain_t4");

    // 5) B stall with a second write queued
    bready = 1'b0;
    write_tx(5'd10, 32'h4000_000C, 32'h1111_1111, 4'hF, 2'b00);
    write_tx(5'd11, 32'h4000_0010, 32'h2222_2222, 4'hF, 2'b00);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_awready", 32'(awready), 32'h0);
      chk("stall_wready", 32'(wready), 32'h0);
      chk("stall_bvalid", 32'(bvalid), 32'h1);
      chk("stall_bid", 32'(bid), 32'd10);
      chk("stall_bresp", 32'(bresp), 32'h0);
      chk("stall_conf4", cslice(4), 32'h0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    drain("drain_t5");
    @(negedge clk);
    chk("t5_conf3", cslice(3), 32'h1111_1111);
    chk("t5_conf4", cslice(4), 32'h2222_2222);
    @(posedge clk); #1;

    // 6) Back-to-back reads at full throughput
    for (int k = 0; k < 4; k++) begin
      arid = 5'(20 + k);
      araddr = 32'h4000_0000 + 32'(k * 4);
      arvalid = 1'b1;
      case (k)
        0: rq.push_back('{5'd20, 32'hCAFE_F00D, 2'b00});
        1: rq.push_back('{5'd21, 32'h0000_0000, 2'b00});
        2: rq.push_back('{5'd22, 32'h12BB_56DD, 2'b00});
        default: rq.push_back('{5'd23, 32'h1111_1111, 2'b00});
      endcase
      @(negedge clk);
      chk("b2b_arready", 32'(arready), 32'h1);
      if (k > 0) chk("b2b_rvalid", 32'(rvalid), 32'h1);
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    drain("drain_b2b");

    // R stall: arready low, R stable
    rready = 1'b0;
    ar_send(5'd30, 32'h4000_0008, 32'h12BB_56DD, 2'b00);
    arid = 5'd31; araddr = 32'h4000_000C; arvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstall_arready", 32'(arready), 32'h0);
      chk("rstall_rvalid", 32'(rvalid), 32'h1);
      chk("rstall_rid", 32'(rid), 32'd30);
      chk("rstall_rdata", rdata, 32'h12BB_56DD);
      @(posedge clk); #1;
    end
    rq.push_back('{5'd31, 32'h1111_1111, 2'b00});
    rready = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    drain("drain_rstall");

    // Reset in the middle of a pending R beat
    rready = 1'b0;
    ar_send(5'd15, 32'h4000_0000, 32'hCAFE_F00D, 2'b00);
    @(negedge clk);
    chk("pre_rst_rvalid", 32'(rvalid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
    chk("mid_rst_rid", 32'(rid), 32'h0);
    chk("mid_rst_conf2", cslice(2), 32'h1234_5678);
    chk("mid_rst_conf3", cslice(3), 32'h0);
    rq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rready = 1'b1;
    @(posedge clk); #1;
    ar_send(5'd16, 32'h4000_0008, 32'h1234_5678, 2'b00);
    drain("drain_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
